regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Issue-gating scoreboard between the instruction queue head and the math pipeline / dcache load path. Tracks one pending-write bit per regfile register (all superscalar threads), holds the queue pop whenever the head instruction would read or overwrite a register with an outstanding write, and provides a drain handshake so control can wait for all in-flight writebacks before program end or a DMA transfer. All state holds while `freeze` is high.

## Interface
- `LOG_SUPERSCALAR_WIDTH`, 4, thread-index bits of a regfile address
- `REG_BITS`, 2, register-index bits per thread; address width `AW = LOG_SUPERSCALAR_WIDTH + REG_BITS` (6), `NUM_REGS = 2**AW` (64)
- `clk  in  1  system clock`
- `reset  in  1  asynchronous, active-low reset`
- `freeze  in  1  global freeze (DMA busy); all state holds`
- `queue_empty  in  1  instruction queue empty`
- `head_rd0_en / head_rd1_en  in  1 each  head reads source 0 / 1`
- `head_rd0_addr / head_rd1_addr  in  AW each  source addresses {thread, reg}`
- `head_wr_en  in  1  head writes a register (math result or cache load)`
- `head_wr_addr  in  AW  destination address`
- `math_wb_we / load_wb_we  in  1 each  writeback strobes (regfile ports c / d)`
- `math_wb_addr / load_wb_addr  in  AW each  writeback addresses`
- `drain_req  in  1  level request: stop issuing, wait for idle`
- `issue  out  1  pop/issue strobe; drives the queue `re``
- `hazard_stall  out  1  head blocked by scoreboard this cycle`
- `drain_done  out  1  state DONE`
- `stall_count  out  16  saturating hazard-stall cycle counter`
- `wb_error  out  1  sticky: writeback to a non-pending register`

## Operation
- `pending[NUM_REGS]` bit vector, registered.
- `hazard = (rd0_en & pending[rd0_addr]) | (rd1_en & pending[rd1_addr]) | (wr_en & pending[wr_addr])`; strict RAW + WAW, no bypass of same-cycle writebacks.
- `issue = reset_deasserted & !freeze & !queue_empty & state==RUN & !hazard`.
- `hazard_stall = !freeze & !queue_empty & state==RUN & hazard`.
- On issue with `head_wr_en`: set `pending[head_wr_addr]`.
- Each writeback strobe clears its address bit; both ports to the same address in one cycle clear it once, no error.
- Writeback to an address whose bit is 0 (and not being set this cycle): set `wb_error`; cleared only by reset.
- Set and clear of the same bit in one cycle cannot arise from a legal issue (WAW stalls it); if it does, set wins and `wb_error` is set.
- `stall_count` increments on `hazard_stall`, saturates at 0xFFFF.
- FSM: RUN -> DRAIN when `drain_req`; DRAIN -> DONE when `pending == 0`; DONE -> RUN when `!drain_req`; `drain_req` dropping in DRAIN returns to RUN. Issue only in RUN.
- `freeze` high: no pending update, no FSM transition, no counter change, writeback strobes ignored (regfile also frozen).

## Timing
- `issue`, `hazard_stall` combinational from registered state and head inputs, same cycle.
- Pending set/clear take effect at the next `clk` edge; a consumer of register R can issue at the earliest one cycle after R's writeback strobe.
- DRAIN -> DONE evaluated on registered `pending`: `drain_done` rises one cycle after the last clearing writeback.
- Reset (asynchronous, any cycle including mid-drain): `pending` all 0, state RUN, `stall_count` 0, `wb_error` 0; `issue`, `hazard_stall`, `drain_done` 0 while reset is asserted.

## Structure
- Shared package: `regfile_addr_t` (AW bits, `{thread, reg}`), scoreboard state enum (RUN, DRAIN, DONE), `AW` and `NUM_REGS` localparams so the regfile and math pipeline use the same address type.
- One sub-module `pending_table`: the bit vector with two clear ports, one set port, freeze, three read ports, `any_pending` output, and the error detection.

## Test plan
- Issue head with wr 0x05; next cycle head reads rd0=0x05 -> `issue`=0, `hazard_stall`=1 until `math_wb_we` @0x05, then `issue`=1 the cycle after.
- Head wr 0x10 while `pending[0x10]`=1 -> stalled (WAW); `load_wb_we` @0x10 -> issues next cycle, `pending[0x10]`=1 again.
- Both wb ports strobe 0x03 in the same cycle with `pending[0x03]`=1 -> bit cleared, `wb_error`=0; `math_wb_we` @0x07 with bit 0 -> `wb_error`=1 and stays 1.
- Pending {0x01, 0x22}, `drain_req`=1 -> `issue`=0; clear 0x01, then 0x22 -> `drain_done`=1 one cycle after; drop `drain_req` -> RUN, issue resumes.
- `freeze`=1 for 5 cycles during a hazard with a writeback strobe -> `pending`, `stall_count`, FSM unchanged; `issue`=0.
- Force 70000 hazard cycles -> `stall_count`=0xFFFF; assert reset mid-DRAIN -> all outputs 0, state RUN immediately.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared regfile address type, scoreboard state encoding and sizing constants
// used by the scoreboard, the regfile and the math pipeline.
package regfile_scoreboard_pkg;

    localparam int LOG_SUPERSCALAR_WIDTH = 4;
    localparam int REG_BITS              = 2;
    localparam int AW                    = LOG_SUPERSCALAR_WIDTH + REG_BITS;
    localparam int NUM_REGS              = 1 << AW;
    localparam logic [15:0] STALL_MAX    = 16'hFFFF;

    // {thread, reg}
    typedef logic [AW-1:0] regfile_addr_t;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic en, input regfile_addr_t addr);
        logic [NUM_REGS-1:0] vec;
        vec       = '0;
        vec[addr] = en;
        return vec;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_pending_table.sv
// One pending-write bit per regfile register: one set port (issue), two clear
// ports (math / load writeback), three lookup ports and sticky error detection.
module pending_table
    import regfile_scoreboard_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          freeze,
    input  logic          set_en,
    input  regfile_addr_t set_addr,
    input  logic          clr0_en,
    input  regfile_addr_t clr0_addr,
    input  logic          clr1_en,
    input  regfile_addr_t clr1_addr,
    input  regfile_addr_t rd0_addr,
    input  regfile_addr_t rd1_addr,
    input  regfile_addr_t rd2_addr,
    output logic          rd0_pend,
    output logic          rd1_pend,
    output logic          rd2_pend,
    output logic          any_pending,
    output logic          wb_error
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] set_vec, clr_vec, err_vec;
    logic                wb_error_q, wb_error_d;

    assign set_vec = addr_onehot(set_en, set_addr);
    // Both ports hitting the same address merge into a single clear.
    assign clr_vec = addr_onehot(clr0_en, clr0_addr) | addr_onehot(clr1_en, clr1_addr);

    always_comb begin
        pending_d  = pending_q;
        err_vec    = '0;
        if (!freeze) begin
            pending_d = set_vec | (pending_q & ~clr_vec);
            // A clear of an idle bit, or a clear racing a set (set wins), is a protocol error.
            err_vec   = clr_vec & (~pending_q | set_vec);
        end
        wb_error_d = wb_error_q | (|err_vec);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            wb_error_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            wb_error_q <= wb_error_d;
        end
    end

    assign rd0_pend    = pending_q[rd0_addr];
    assign rd1_pend    = pending_q[rd1_addr];
    assign rd2_pend    = pending_q[rd2_addr];
    assign any_pending = |pending_q;
    assign wb_error    = wb_error_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue gate between the instruction queue head and the writeback paths:
// blocks RAW/WAW hazards, counts stall cycles and runs the drain handshake.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          freeze,
    input  logic          queue_empty,
    input  logic          head_rd0_en,
    input  logic [AW-1:0] head_rd0_addr,
    input  logic          head_rd1_en,
    input  logic [AW-1:0] head_rd1_addr,
    input  logic          head_wr_en,
    input  logic [AW-1:0] head_wr_addr,
    input  logic          math_wb_we,
    input  logic [AW-1:0] math_wb_addr,
    input  logic          load_wb_we,
    input  logic [AW-1:0] load_wb_addr,
    input  logic          drain_req,
    output logic          issue,
    output logic          hazard_stall,
    output logic          drain_done,
    output logic [15:0]   stall_count,
    output logic          wb_error
);

    sb_state_t   state_q, state_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        rd0_pend, rd1_pend, wr_pend, any_pending;
    logic        hazard, head_live;

    pending_table u_pending_table (
        .clk         (clk),
        .reset       (reset),
        .freeze      (freeze),
        .set_en      (issue & head_wr_en),
        .set_addr    (regfile_addr_t'(head_wr_addr)),
        .clr0_en     (math_wb_we),
        .clr0_addr   (regfile_addr_t'(math_wb_addr)),
        .clr1_en     (load_wb_we),
        .clr1_addr   (regfile_addr_t'(load_wb_addr)),
        .rd0_addr    (regfile_addr_t'(head_rd0_addr)),
        .rd1_addr    (regfile_addr_t'(head_rd1_addr)),
        .rd2_addr    (regfile_addr_t'(head_wr_addr)),
        .rd0_pend    (rd0_pend),
        .rd1_pend    (rd1_pend),
        .rd2_pend    (wr_pend),
        .any_pending (any_pending),
        .wb_error    (wb_error)
    );

    // Strict RAW + WAW: a writeback in this same cycle does not unblock the head.
    assign hazard    = (head_rd0_en & rd0_pend) | (head_rd1_en & rd1_pend) | (head_wr_en & wr_pend);
    assign head_live = reset & ~freeze & ~queue_empty & (state_q == SB_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SB_RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Drain completes on the registered pending vector, one cycle behind the last clear.
    always_comb begin
        state_d = state_q;
        if (!freeze) begin
            unique case (state_q)
                SB_RUN:   if (drain_req) state_d = SB_DRAIN;
                SB_DRAIN: begin
                    if (!drain_req)        state_d = SB_RUN;
                    else if (!any_pending) state_d = SB_DONE;
                end
                SB_DONE:  if (!drain_req) state_d = SB_RUN;
                default:  state_d = SB_RUN;
            endcase
        end
    end

    always_comb begin
        issue        = head_live & ~hazard;
        hazard_stall = head_live & hazard;
        drain_done   = (state_q == SB_DONE);
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard_stall && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against a register-level
// behavioural model of pending writes, drain handshake and counters.
`timescale 1ns/1ps
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset, freeze, queue_empty, drain_req;
    logic        head_rd0_en, head_rd1_en, head_wr_en, math_wb_we, load_wb_we;
    logic [5:0]  head_rd0_addr, head_rd1_addr, head_wr_addr, math_wb_addr, load_wb_addr;
    logic        issue, hazard_stall, drain_done, wb_error;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .freeze        (freeze),
        .queue_empty   (queue_empty),
        .head_rd0_en   (head_rd0_en),
        .head_rd0_addr (head_rd0_addr),
        .head_rd1_en   (head_rd1_en),
        .head_rd1_addr (head_rd1_addr),
        .head_wr_en    (head_wr_en),
        .head_wr_addr  (head_wr_addr),
        .math_wb_we    (math_wb_we),
        .math_wb_addr  (math_wb_addr),
        .load_wb_we    (load_wb_we),
        .load_wb_addr  (load_wb_addr),
        .drain_req     (drain_req),
        .issue         (issue),
        .hazard_stall  (hazard_stall),
        .drain_done    (drain_done),
        .stall_count   (stall_count),
        .wb_error      (wb_error)
    );

    // Reference model: which registers await a write, plus drain phase and counters.
    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;
    bit m_pend [64];
    int m_state;
    int m_cnt;
    bit m_err;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
        m_state = M_RUN;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic idle();
        freeze      = 1'b0; queue_empty = 1'b1; drain_req  = 1'b0;
        head_rd0_en = 1'b0; head_rd1_en = 1'b0; head_wr_en = 1'b0;
        math_wb_we  = 1'b0; load_wb_we  = 1'b0;
        head_rd0_addr = '0; head_rd1_addr = '0; head_wr_addr = '0;
        math_wb_addr  = '0; load_wb_addr  = '0;
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic tick();
        bit haz, ex_issue, ex_stall, any, setting;
        #2;
        haz = (head_rd0_en && m_pend[head_rd0_addr]) || (head_rd1_en && m_pend[head_rd1_addr])
              || (head_wr_en && m_pend[head_wr_addr]);
        ex_issue = !freeze && !queue_empty && (m_state == M_RUN) && !haz;
        ex_stall = !freeze && !queue_empty && (m_state == M_RUN) && haz;
        check("issue", 32'(issue), 32'(ex_issue));
        check("hazard_stall", 32'(hazard_stall), 32'(ex_stall));
        check("drain_done", 32'(drain_done), 32'(m_state == M_DONE));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
        check("wb_error", 32'(wb_error), 32'(m_err));
        if (!freeze) begin
            any = 1'b0;
            for (int i = 0; i < 64; i++) any |= m_pend[i];
            setting = ex_issue && head_wr_en;
            if (math_wb_we && (!m_pend[math_wb_addr] || (setting && head_wr_addr == math_wb_addr))) m_err = 1'b1;
            if (load_wb_we && (!m_pend[load_wb_addr] || (setting && head_wr_addr == load_wb_addr))) m_err = 1'b1;
            if (math_wb_we) m_pend[math_wb_addr] = 1'b0;
            if (load_wb_we) m_pend[load_wb_addr] = 1'b0;
            if (setting) m_pend[head_wr_addr] = 1'b1;
            if (ex_stall && m_cnt < 65535) m_cnt++;
            case (m_state)
                M_RUN:   if (drain_req) m_state = M_DRAIN;
                M_DRAIN: if (!drain_req) m_state = M_RUN; else if (!any) m_state = M_DONE;
                default: if (!drain_req) m_state = M_RUN;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [5:0] pool_addr();
        logic [5:0] pool [8];
        pool = '{6'h00, 6'h05, 6'h10, 6'h22, 6'h3F, 6'h2A, 6'h13, 6'h31};
        return pool[$urandom_range(0, 7)];
    endfunction

    // Pick a currently pending register so random writebacks stay legal.
    function automatic bit pick_pending(output logic [5:0] addr);
        int q[$];
        for (int i = 0; i < 64; i++) if (m_pend[i]) q.push_back(i);
        addr = '0;
        if (q.size() == 0) return 1'b0;
        addr = 6'(q[$urandom_range(0, q.size() - 1)]);
        return 1'b1;
    endfunction

    task automatic flush();
        for (int i = 0; i < 64; i++) begin
            if (m_pend[i]) begin
                idle(); math_wb_we = 1'b1; math_wb_addr = 6'(i); tick();
            end
        end
        idle(); tick(); tick();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        queue_empty = 1'b0;
        model_reset();
        #1;
        check("rst_issue", 32'(issue), 32'd0);
        check("rst_stall", 32'(hazard_stall), 32'd0);
        check("rst_done", 32'(drain_done), 32'd0);
        check("rst_count", 32'(stall_count), 32'd0);
        check("rst_err", 32'(wb_error), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        idle();

        // RAW on 0x05 until its math writeback
        queue_empty = 1'b0; head_wr_en = 1'b1; head_wr_addr = 6'h05; tick();
        head_wr_en = 1'b0; head_rd0_en = 1'b1; head_rd0_addr = 6'h05;
        tick(); tick(); tick();
        math_wb_we = 1'b1; math_wb_addr = 6'h05; tick();
        math_wb_we = 1'b0; tick();
        check("raw_count", 32'(stall_count), 32'd4);

        // WAW on 0x10 released by the load writeback
        idle(); queue_empty = 1'b0; head_wr_en = 1'b1; head_wr_addr = 6'h10; tick();
        tick();
        load_wb_we = 1'b1; load_wb_addr = 6'h10; tick();
        load_wb_we = 1'b0; tick();
        head_wr_en = 1'b0; head_rd1_en = 1'b1; head_rd1_addr = 6'h10; tick();
        idle(); load_wb_we = 1'b1; load_wb_addr = 6'h10; tick();

        // Dual writeback of one address clears once, no error
        idle(); queue_empty = 1'b0; head_wr_en = 1'b1; head_wr_addr = 6'h03; tick();
        idle(); math_wb_we = 1'b1; math_wb_addr = 6'h03; load_wb_we = 1'b1; load_wb_addr = 6'h03; tick();
        idle(); tick();
        check("dual_wb_err", 32'(wb_error), 32'd0);

        // Drain with 0x01 and 0x22 outstanding
        queue_empty = 1'b0; head_wr_en = 1'b1; head_wr_addr = 6'h01; tick();
        head_wr_addr = 6'h22; tick();
        idle(); drain_req = 1'b1; tick();
        queue_empty = 1'b0; head_wr_en = 1'b1; head_wr_addr = 6'h30; tick();
        math_wb_we = 1'b1; math_wb_addr = 6'h01; tick();
        math_wb_addr = 6'h22; tick();
        math_wb_we = 1'b0; tick();
        tick();
        check("drain_done_hi", 32'(drain_done), 32'd1);
        drain_req = 1'b0; tick();
        tick();
        idle(); math_wb_we = 1'b1; math_wb_addr = 6'h30; tick();

        // Freeze during a hazard with a writeback strobe
        idle(); queue_empty = 1'b0; head_wr_en = 1'b1; head_wr_addr = 6'h05; tick();
        head_wr_en = 1'b0; head_rd0_en = 1'b1; head_rd0_addr = 6'h05; tick();
        freeze = 1'b1; math_wb_we = 1'b1; math_wb_addr = 6'h05;
        repeat (5) tick();
        freeze = 1'b0; math_wb_we = 1'b0; tick();
        math_wb_we = 1'b1; tick();
        idle(); tick();

        // Randomized traffic with legal writebacks
        for (int n = 0; n < 800; n++) begin
            logic [5:0] a;
            freeze      = ($urandom_range(0, 9) == 0);
            queue_empty = ($urandom_range(0, 4) == 0);
            head_rd0_en = 1'($urandom_range(0, 1)); head_rd0_addr = pool_addr();
            head_rd1_en = 1'($urandom_range(0, 1)); head_rd1_addr = pool_addr();
            head_wr_en  = 1'($urandom_range(0, 1)); head_wr_addr  = pool_addr();
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            math_wb_we = ($urandom_range(0, 2) == 0) && pick_pending(a); math_wb_addr = a;
            load_wb_we = ($urandom_range(0, 2) == 0) && pick_pending(a); load_wb_addr = a;
            tick();
        end
        flush();

        // Writeback to an idle register is a sticky error
        math_wb_we = 1'b1; math_wb_addr = 6'h07; tick();
        idle(); tick(); tick();
        check("wb_err_sticky", 32'(wb_error), 32'd1);

        // Saturate the stall counter, then reset asynchronously mid-drain
        queue_empty = 1'b0; head_wr_en = 1'b1; head_wr_addr = 6'h2A; tick();
        head_wr_en = 1'b0; head_rd1_en = 1'b1; head_rd1_addr = 6'h2A;
        repeat (66000) tick();
        check("count_sat", 32'(stall_count), 32'h0000FFFF);
        drain_req = 1'b1; tick(); tick();
        #3;
        reset = 1'b0;
        #1;
        check("arst_issue", 32'(issue), 32'd0);
        check("arst_stall", 32'(hazard_stall), 32'd0);
        check("arst_done", 32'(drain_done), 32'd0);
        check("arst_count", 32'(stall_count), 32'd0);
        check("arst_err", 32'(wb_error), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1; drain_req = 1'b0;
        tick();
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
